player_move_ctrl: RTL and testbench

Movement sequencer for the player rectangle in the maze game. On each move-rate tick it samples the buttons, looks up the target cell in the maze map through a request/acknowledge port, and then does one of three things:
- grants the move with a one-cycle direction enable to the player rectangle,
- blocks it, or
- ends the game.

It tracks the player's grid cell so the rectangle datapath only applies the offsets it is granted.

---
 rtl/player_move_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_player_move_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_move_ctrl.sv
// Movement sequencer for the maze player: samples buttons on the move tick, checks the
// target cell through the map request/ack port, then grants, blocks or ends the game.
module player_move_ctrl #(
  parameter int unsigned MAP_COLS  = 32,
  parameter int unsigned MAP_ROWS  = 40,
  parameter int unsigned START_COL = 16,
  parameter int unsigned START_ROW = 37,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              slowClk,
  input  logic              rst,
  input  logic              tick,
  input  logic [3:0]        btns,
  input  logic              playerDisable,
  output logic              map_req,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_ack,
  input  logic [1:0]        map_data,
  output logic              upEnable,
  output logic              downEnable,
  output logic              leftEnable,
  output logic              rightEnable,
  output logic [5:0]        col,
  output logic [5:0]        row,
  output logic              busy,
  output logic              player_dead,
  output logic              level_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [5:0] COL_MAX   = 6'(MAP_COLS - 1);
  localparam logic [5:0] ROW_MAX   = 6'(MAP_ROWS - 1);
  localparam logic [5:0] COL_RESET = 6'(START_COL);
  localparam logic [5:0] ROW_RESET = 6'(START_ROW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CELL_OPEN   = 2'd0;
  localparam logic [1:0] CELL_WALL   = 2'd1;
  localparam logic [1:0] CELL_HAZARD = 2'd2;
  localparam logic [1:0] CELL_GOAL   = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    MOVE = 3'd2,
    DEAD = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  state_t           state;
  dir_t             dir_q;
  logic [5:0]       tgt_col_q;
  logic [5:0]       tgt_row_q;
  logic             goal_q;
  logic [CNT_W-1:0] wait_cnt;

  dir_t             sel_dir;
  logic             at_edge;
  logic [5:0]       tgt_col;
  logic [5:0]       tgt_row;
  logic [ADDR_W-1:0] tgt_addr;
  logic             start_move;

  // Button priority (up > down > left > right), target cell and grid-edge detection
  always_comb begin
    sel_dir = DIR_UP;
    at_edge = 1'b0;
    tgt_col = col;
    tgt_row = row;
    if (btns[0]) begin
      sel_dir = DIR_UP;
      at_edge = (row == 6'd0);
      tgt_row = row - 6'd1;
    end else if (btns[1]) begin
      sel_dir = DIR_DOWN;
      at_edge = (row == ROW_MAX);
      tgt_row = row + 6'd1;
    end else if (btns[2]) begin
      sel_dir = DIR_LEFT;
      at_edge = (col == 6'd0);
      tgt_col = col - 6'd1;
    end else if (btns[3]) begin
      sel_dir = DIR_RIGHT;
      at_edge = (col == COL_MAX);
      tgt_col = col + 6'd1;
    end
  end

  assign tgt_addr   = ADDR_W'(tgt_row) * ADDR_W'(MAP_COLS) + ADDR_W'(tgt_col);
  assign start_move = tick && !playerDisable && (btns != 4'd0) && !at_edge;

  // Sequencer; enables, position and flags are all registered here
  always_ff @(posedge slowClk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dir_q       <= DIR_UP;
      tgt_col_q   <= COL_RESET;
      tgt_row_q   <= ROW_RESET;
      goal_q      <= 1'b0;
      wait_cnt    <= '0;
      map_req     <= 1'b0;
      map_addr    <= '0;
      upEnable    <= 1'b0;
      downEnable  <= 1'b0;
      leftEnable  <= 1'b0;
      rightEnable <= 1'b0;
      col         <= COL_RESET;
      row         <= ROW_RESET;
      busy        <= 1'b0;
      player_dead <= 1'b0;
      level_done  <= 1'b0;
    end else begin
      upEnable    <= 1'b0;
      downEnable  <= 1'b0;
      leftEnable  <= 1'b0;
      rightEnable <= 1'b0;

      case (state)
        IDLE: begin
          if (start_move) begin
            dir_q     <= sel_dir;
            tgt_col_q <= tgt_col;
            tgt_row_q <= tgt_row;
            goal_q    <= 1'b0;
            wait_cnt  <= '0;
            map_addr  <= tgt_addr;
            map_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (map_ack) begin
            map_req <= 1'b0;
            if (playerDisable) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              case (map_data)
                CELL_OPEN, CELL_GOAL: begin
                  upEnable    <= (dir_q == DIR_UP);
                  downEnable  <= (dir_q == DIR_DOWN);
                  leftEnable  <= (dir_q == DIR_LEFT);
                  rightEnable <= (dir_q == DIR_RIGHT);
                  col         <= tgt_col_q;
                  row         <= tgt_row_q;
                  goal_q      <= (map_data == CELL_GOAL);
                  state       <= MOVE;
                end
                CELL_HAZARD: begin
                  player_dead <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DEAD;
                end
                CELL_WALL: begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
                default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              endcase
            end
          end else if (wait_cnt == CNT_LAST) begin
            // Map never answered: give up and treat the cell as a wall
            map_req <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        MOVE: begin
          busy <= 1'b0;
          if (goal_q) begin
            level_done <= 1'b1;
            state      <= DONE;
          end else begin
            state <= IDLE;
          end
        end

        DEAD: state <= DEAD;

        DONE: state <= DONE;

        default: begin
          map_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: open/wall/edge/hazard/goal/timeout/disable/reset cases.
module tb_player_move_ctrl;

  logic        slowClk;
  logic        rst;
  logic        tick;
  logic [3:0]  btns;
  logic        playerDisable;
  logic        map_req;
  logic [10:0] map_addr;
  logic        map_ack;
  logic [1:0]  map_data;
  logic        upEnable;
  logic        downEnable;
  logic        leftEnable;
  logic        rightEnable;
  logic [5:0]  col;
  logic [5:0]  row;
  logic        busy;
  logic        player_dead;
  logic        level_done;

  int n_tests;
  int n_fail;

  player_move_ctrl dut (
    .slowClk       (slowClk),
    .rst           (rst),
    .tick          (tick),
    .btns          (btns),
    .playerDisable (playerDisable),
    .map_req       (map_req),
    .map_addr      (map_addr),
    .map_ack       (map_ack),
    .map_data      (map_data),
    .upEnable      (upEnable),
    .downEnable    (downEnable),
    .leftEnable    (leftEnable),
    .rightEnable   (rightEnable),
    .col           (col),
    .row           (row),
    .busy          (busy),
    .player_dead   (player_dead),
    .level_done    (level_done)
  );

  initial slowClk = 1'b0;
  always #5 slowClk = ~slowClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling
  task automatic clk_step();
    @(posedge slowClk);
    #1;
  endtask

  function automatic logic [31:0] enables();
    return 32'({rightEnable, leftEnable, downEnable, upEnable});
  endfunction

  task automatic do_reset();
    rst           = 1'b0;
    tick          = 1'b0;
    btns          = 4'd0;
    playerDisable = 1'b0;
    map_ack       = 1'b0;
    map_data      = 2'd0;
    clk_step();
    clk_step();
    rst = 1'b1;
    clk_step();
  endtask

  // Tick with buttons b, answer in cycle k with data d; returns in cycle k+1
  task automatic do_move(input logic [3:0] b, input logic [1:0] d, input int k);
    btns = b;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    for (int i = 1; i < k; i++) clk_step();
    map_ack  = 1'b1;
    map_data = d;
    clk_step();
    map_ack  = 1'b0;
    btns     = 4'd0;
  endtask

  initial begin
    logic req_seen;
    n_tests = 0;
    n_fail  = 0;

    // Reset state
    do_reset();
    check("rst_col", 32'(col), 32'd16);
    check("rst_row", 32'(row), 32'd37);
    check("rst_addr", 32'(map_addr), 32'd0);
    check("rst_req", 32'(map_req), 32'd0);
    check("rst_en", enables(), 32'd0);
    check("rst_flags", 32'({busy, player_dead, level_done}), 32'd0);

    // Open move up, ack in cycle 2
    btns = 4'b0001;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    check("open_req", 32'(map_req), 32'd1);
    check("open_addr", 32'(map_addr), 32'd1168);
    check("open_busy", 32'(busy), 32'd1);
    btns = 4'b0010;
    map_ack  = 1'b1;
    map_data = 2'd0;
    clk_step();
    map_ack = 1'b0;
    check("open_en", enables(), 32'b0001);
    check("open_row", 32'(row), 32'd36);
    check("open_req_drop", 32'(map_req), 32'd0);
    tick = 1'b1;
    btns = 4'b0001;
    clk_step();
    tick = 1'b0;
    btns = 4'd0;
    check("open_en_once", enables(), 32'd0);
    check("busy_tick_drop", 32'(map_req), 32'd0);
    check("open_idle", 32'(busy), 32'd0);

    // Wall with priority left over right
    do_reset();
    do_move(4'b1100, 2'd1, 2);
    check("wall_en", enables(), 32'd0);
    check("wall_col", 32'(col), 32'd16);
    check("wall_busy", 32'(busy), 32'd0);
    check("wall_addr", 32'(map_addr), 32'd1199);

    // Walk left to the grid edge, then try once more
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_move(4'b0100, 2'd0, 1);
      clk_step();
    end
    check("edge_col0", 32'(col), 32'd0);
    req_seen = 1'b0;
    btns = 4'b0100;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (map_req || busy || enables() != 32'd0) req_seen = 1'b1;
      clk_step();
    end
    btns = 4'd0;
    check("edge_quiet", 32'(req_seen), 32'd0);
    check("edge_col_hold", 32'(col), 32'd0);

    // Hazard
    do_reset();
    do_move(4'b0001, 2'd2, 3);
    check("haz_dead", 32'(player_dead), 32'd1);
    check("haz_en", enables(), 32'd0);
    check("haz_row", 32'(row), 32'd37);
    btns = 4'b0001;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    clk_step();
    check("haz_no_req", 32'(map_req), 32'd0);
    check("haz_sticky", 32'({player_dead, busy}), 32'b10);

    // Goal
    do_reset();
    do_move(4'b1000, 2'd3, 1);
    check("goal_en", enables(), 32'b1000);
    check("goal_col", 32'(col), 32'd17);
    check("goal_done_early", 32'(level_done), 32'd0);
    clk_step();
    check("goal_done", 32'(level_done), 32'd1);
    check("goal_en_off", enables(), 32'd0);
    btns = 4'b0010;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    btns = 4'd0;
    check("goal_no_req", 32'(map_req), 32'd0);

    // Timeout: map_req high for 15 cycles in REQ then dropped
    do_reset();
    btns = 4'b0010;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    btns = 4'd0;
    for (int i = 0; i < 14; i++) clk_step();
    check("to_req_c15", 32'(map_req), 32'd1);
    clk_step();
    check("to_req_c16", 32'(map_req), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
    map_ack  = 1'b1;
    map_data = 2'd0;
    clk_step();
    map_ack = 1'b0;
    check("to_late_ack", enables(), 32'd0);
    check("to_pos", 32'({col, row}), 32'({6'd16, 6'd37}));

    // playerDisable at the ack edge discards the result
    do_reset();
    btns = 4'b0001;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    btns = 4'd0;
    playerDisable = 1'b1;
    map_ack  = 1'b1;
    map_data = 2'd0;
    clk_step();
    map_ack = 1'b0;
    playerDisable = 1'b0;
    check("dis_en", enables(), 32'd0);
    check("dis_row", 32'(row), 32'd37);
    check("dis_busy", 32'(busy), 32'd0);

    // Reset in the middle of a request
    do_reset();
    do_move(4'b1000, 2'd0, 1);
    clk_step();
    btns = 4'b0001;
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    btns = 4'd0;
    check("mid_req_up", 32'(map_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_req_drop", 32'(map_req), 32'd0);
    check("mid_pos", 32'({col, row}), 32'({6'd16, 6'd37}));
    check("mid_addr", 32'(map_addr), 32'd0);
    #3;
    rst = 1'b1;
    clk_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
